serial_sub8: RTL

Bit-serial subtractor that computes Diff = A - B - bIn over WIDTH clock cycles, processing the LSB first. It uses a start/busy/done handshake. It is the subtraction counterpart to the combinational ripple adder datapath and trades area for latency: one full-subtractor cell plus shift registers. Downstream logic samples diff/bOut when done pulses.

---
 rtl/serial_sub8.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_sub8.sv
// ---------------------------------------------------------------------------
// serial_sub8 -- bit-serial subtractor, Diff = A - B - bIn (mod 2^WIDTH)
//
// One full-subtractor cell handles one bit per clock, LSB first. An accepted
// start captures the operands. WIDTH shift cycles follow. done then pulses
// for one cycle, and diff/bOut hold the result until the next completion or
// until reset.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high; overrides everything
//   start  in   request; sampled only while idle
//   A      in   WIDTH-bit minuend, captured on accepted start
//   B      in   WIDTH-bit subtrahend, captured on accepted start
//   bIn    in   borrow-in, captured on accepted start
//   busy   out  high while a subtraction is in progress (WIDTH cycles)
//   done   out  one-cycle completion pulse
//   diff   out  WIDTH-bit result, valid from the done cycle onward
//   bOut   out  final borrow-out (1 when A < B + bIn, unsigned)
// ---------------------------------------------------------------------------
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bOut
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } stateType;

    stateType         state;
    stateType         stateNext;

    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shiftReg;

    logic             dBit;
    logic             borrowNext;
    logic [WIDTH-1:0] shiftNext;
    logic             lastBit;

    // Full-subtractor cell working on the current LSB of the operands.
    assign dBit       = regA[0] ^ regB[0] ^ borrow;
    assign borrowNext = (~regA[0] & regB[0]) | (~(regA[0] ^ regB[0]) & borrow);
    // Result bits enter at the MSB. After WIDTH shifts the first bit sits at bit 0.
    assign shiftNext  = {dBit, shiftReg[WIDTH-1:1]};
    assign lastBit    = (cnt == LAST_CNT);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // flop then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: default assignment first, so no path leaves stateNext unassigned
    // and no latch is inferred.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start)   stateNext = SHIFT;
            SHIFT:   if (lastBit) stateNext = IDLE;
            default:              stateNext = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy = (state == SHIFT);
    end

    // ---------------- datapath ----------------
    // NOTE: every register is reset here, shift registers included. An
    // aborted operation must not leave stale operand bits that a later start
    // would only partly overwrite.
    always_ff @(posedge clk) begin
        if (reset) begin
            regA     <= '0;
            regB     <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            shiftReg <= '0;
            diff     <= '0;
            bOut     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        regA     <= A;
                        regB     <= B;
                        borrow   <= bIn;
                        cnt      <= '0;
                        shiftReg <= '0;
                    end
                end
                SHIFT: begin
                    regA     <= regA >> 1;
                    regB     <= regB >> 1;
                    borrow   <= borrowNext;
                    shiftReg <= shiftNext;
                    cnt      <= cnt + CNT_W'(1);
                    if (lastBit) begin
                        diff <= shiftNext;
                        bOut <= borrowNext;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
